// File: rtl/sipo_deframer.sv
// Purpose: rebuilds WIDTH-bit words from a framed MSB-first serial stream (start bit, data, optional even parity).
// Latency: out_valid rises on the clock edge that samples the last data or parity bit; no added cycles.
// Backpressure: one-word output register; a word completed while the register is full and not being accepted is dropped and flagged in sticky overflow.
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             sin,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             parity_err,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic             cnt_clr;
  logic             shift_en;
  logic             done;
  logic             perr;
  logic             load;
  logic             drop;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus per-edge control strobes; only bit_en edges advance the frame.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    done      = 1'b0;
    perr      = 1'b0;
    case (state)
      IDLE: begin
        if (bit_en && sin) begin
          state_nxt = DATA;
          cnt_clr   = 1'b1;
        end
      end
      DATA: begin
        if (bit_en) begin
          shift_en = 1'b1;
          if (cnt == LAST) begin
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
            end else begin
              state_nxt = IDLE;
              done      = 1'b1;
            end
          end
        end
      end
      PARITY: begin
        if (bit_en) begin
          state_nxt = IDLE;
          done      = 1'b1;
          perr      = ^{shreg, sin};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Without parity the last data bit completes the word on the same edge, so bypass it into the result.
  always_comb begin
    word = (state == PARITY) ? shreg : {shreg[WIDTH-2:0], sin};
    load = done && (!out_valid || out_ready);
    drop = done && out_valid && !out_ready;
  end

  // Bit counter and shift register; a start bit restarts the count so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt <= cnt + 1'b1;
      end
      if (shift_en) begin
        shreg <= {shreg[WIDTH-2:0], sin};
      end
    end
  end

  // Output register: load on completion if empty or draining this edge, otherwise clear on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else if (load) begin
      out_data   <= word;
      parity_err <= perr;
      out_valid  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Sticky overflow; a drop on the same edge as clr_err keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_err) begin
      overflow <= 1'b0;
    end
  end

  // busy tracks the state register exactly by loading from the next-state value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: one instance without parity, one with even parity.
// Inputs change 2 time units after each rising edge; outputs are checked there or on the falling edge.
// A falling-edge monitor pops the expected-word queue on every handshake of the non-parity instance.
module tb_sipo_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic       be0 = 1'b0, sin0 = 1'b0;
  logic       be1 = 1'b0, sin1 = 1'b0;
  logic [3:0] d0, d1;
  logic       v0, v1, pe0, pe1, ov0, ov1, bz0, bz1;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  sipo_deframer #(.WIDTH(4), .PARITY_EN(0)) u_np (
    .clk(clk), .rst(rst), .bit_en(be0), .sin(sin0), .out_ready(out_ready), .clr_err(clr_err),
    .out_data(d0), .out_valid(v0), .parity_err(pe0), .overflow(ov0), .busy(bz0)
  );

  sipo_deframer #(.WIDTH(4), .PARITY_EN(1)) u_par (
    .clk(clk), .rst(rst), .bit_en(be1), .sin(sin1), .out_ready(out_ready), .clr_err(clr_err),
    .out_data(d1), .out_valid(v1), .parity_err(pe1), .overflow(ov1), .busy(bz1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake on the non-parity instance must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && v0 && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no word", d0);
      end else begin
        chk("sb_word", {28'd0, d0}, {28'd0, sb_q.pop_front()});
      end
    end
  end

  // One clock: drive strobe/serial for the selected instance, consume an edge, release the strobe.
  task automatic cyc(input bit sel, input logic be, input logic s);
    if (sel) begin be1 = be; sin1 = s; end
    else     begin be0 = be; sin0 = s; end
    @(posedge clk);
    #2;
    be0 = 1'b0;
    be1 = 1'b0;
  endtask

  // Full frame; gap idle cycles (with a toggling line) precede every strobed bit.
  task automatic send_frame(input bit sel, input logic [3:0] data, input bit par_en,
                            input logic par_bit, input int gap);
    logic [5:0] bits;
    int         n;
    bits = {1'b1, data, par_bit};
    n    = par_en ? 6 : 5;
    for (int i = 0; i < n; i++) begin
      repeat (gap) cyc(sel, 1'b0, ~bits[5-i]);
      cyc(sel, 1'b1, bits[5-i]);
    end
  endtask

  typedef struct {
    bit         sel;
    logic [3:0] data;
    logic       par_bit;
    int         gap;
    logic [3:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{sel: 1'b0, data: 4'hA, par_bit: 1'b0, gap: 0, exp_data: 4'b1010, exp_perr: 1'b0};
    tbl[1] = '{sel: 1'b0, data: 4'h5, par_bit: 1'b0, gap: 0, exp_data: 4'h5,    exp_perr: 1'b0};
    tbl[2] = '{sel: 1'b0, data: 4'hC, par_bit: 1'b0, gap: 0, exp_data: 4'hC,    exp_perr: 1'b0};
    tbl[3] = '{sel: 1'b1, data: 4'hB, par_bit: 1'b1, gap: 0, exp_data: 4'hB,    exp_perr: 1'b0};
    tbl[4] = '{sel: 1'b1, data: 4'hB, par_bit: 1'b0, gap: 0, exp_data: 4'hB,    exp_perr: 1'b1};
    tbl[5] = '{sel: 1'b0, data: 4'h9, par_bit: 1'b0, gap: 2, exp_data: 4'h9,    exp_perr: 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_data",  {28'd0, d0}, 32'd0);
    chk("rst_valid", {31'd0, v0}, 32'd0);
    chk("rst_perr",  {31'd0, pe0}, 32'd0);
    chk("rst_ovf",   {31'd0, ov0}, 32'd0);
    chk("rst_busy",  {31'd0, bz0}, 32'd0);
    rst = 1'b1;
    cyc(0, 1'b0, 1'b0);

    // Table: single frames, back-to-back frames, parity good/bad, sparse strobe
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (!tbl[i].sel) sb_q.push_back(tbl[i].exp_data);
      send_frame(tbl[i].sel, tbl[i].data, tbl[i].sel, tbl[i].par_bit, tbl[i].gap);
      if (tbl[i].sel) begin
        chk($sformatf("vec%0d_valid", i), {31'd0, v1}, 32'd1);
        chk($sformatf("vec%0d_data", i),  {28'd0, d1}, {28'd0, tbl[i].exp_data});
        chk($sformatf("vec%0d_perr", i),  {31'd0, pe1}, {31'd0, tbl[i].exp_perr});
      end else begin
        chk($sformatf("vec%0d_valid", i), {31'd0, v0}, 32'd1);
        chk($sformatf("vec%0d_data", i),  {28'd0, d0}, {28'd0, tbl[i].exp_data});
        chk($sformatf("vec%0d_perr", i),  {31'd0, pe0}, 32'd0);
      end
    end
    repeat (3) cyc(0, 1'b0, 1'b0);
    chk("idle_busy",  {31'd0, bz0}, 32'd0);
    chk("idle_valid", {31'd0, v0}, 32'd0);
    chk("idle_ovf",   {31'd0, ov0}, 32'd0);

    // Parity frame: out_valid must stay low until the parity-bit edge
    cyc(1, 1'b1, 1'b1);
    cyc(1, 1'b1, 1'b1);
    cyc(1, 1'b1, 1'b0);
    cyc(1, 1'b1, 1'b1);
    cyc(1, 1'b1, 1'b1);
    chk("par_wait_valid", {31'd0, v1}, 32'd0);
    chk("par_wait_busy",  {31'd0, bz1}, 32'd1);
    cyc(1, 1'b1, 1'b1);
    chk("par_done_valid", {31'd0, v1}, 32'd1);
    chk("par_done_perr",  {31'd0, pe1}, 32'd0);
    cyc(1, 1'b0, 1'b0);

    // Stalled consumer: second frame dropped, first word held
    out_ready = 1'b0;
    sb_q.push_back(4'hA);
    send_frame(0, 4'hA, 0, 1'b0, 0);
    chk("stall1_ovf", {31'd0, ov0}, 32'd0);
    send_frame(0, 4'h3, 0, 1'b0, 0);
    chk("stall2_data",  {28'd0, d0}, 32'hA);
    chk("stall2_valid", {31'd0, v0}, 32'd1);
    chk("stall2_ovf",   {31'd0, ov0}, 32'd1);
    out_ready = 1'b1;
    cyc(0, 1'b0, 1'b0);
    out_ready = 1'b0;
    chk("drain_valid", {31'd0, v0}, 32'd0);
    chk("drain_ovf",   {31'd0, ov0}, 32'd1);
    clr_err = 1'b1;
    cyc(0, 1'b0, 1'b0);
    clr_err = 1'b0;
    chk("clr_ovf", {31'd0, ov0}, 32'd0);

    // Drop coinciding with clr_err: the set must win
    sb_q.push_back(4'h6);
    send_frame(0, 4'h6, 0, 1'b0, 0);
    clr_err = 1'b1;
    send_frame(0, 4'h7, 0, 1'b0, 0);
    clr_err = 1'b0;
    chk("setwins_ovf",  {31'd0, ov0}, 32'd1);
    chk("setwins_data", {28'd0, d0}, 32'h6);
    out_ready = 1'b1;
    clr_err = 1'b1;
    cyc(0, 1'b0, 1'b0);
    clr_err = 1'b0;
    chk("setwins_clr", {31'd0, ov0}, 32'd0);

    // Async reset mid-frame with a word pending, then a clean frame
    out_ready = 1'b0;
    send_frame(0, 4'hD, 0, 1'b0, 0);
    cyc(0, 1'b1, 1'b1);
    cyc(0, 1'b1, 1'b1);
    cyc(0, 1'b1, 1'b1);
    chk("pre_rst_busy",  {31'd0, bz0}, 32'd1);
    chk("pre_rst_valid", {31'd0, v0}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, v0}, 32'd0);
    chk("arst_data",  {28'd0, d0}, 32'd0);
    chk("arst_busy",  {31'd0, bz0}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    cyc(0, 1'b0, 1'b0);
    out_ready = 1'b1;
    sb_q.push_back(4'h6);
    send_frame(0, 4'h6, 0, 1'b0, 0);
    chk("post_rst_valid", {31'd0, v0}, 32'd1);
    chk("post_rst_data",  {28'd0, d0}, 32'h6);
    repeat (3) cyc(0, 1'b0, 1'b0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
